// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the single-bank DRAM controller: FSM states,
// command pin encoding and default timing.
package dram_ctrl_pkg;

  localparam int unsigned DefTRp  = 5;
  localparam int unsigned DefTRcd = 5;
  localparam int unsigned DefTCl  = 5;
  localparam int unsigned DefTWr  = 5;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StPreWait,
    StAct,
    StActWait,
    StCol,
    StColWait,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    CmdNop,
    CmdPre,
    CmdAct,
    CmdRd,
    CmdWr
  } cmd_e;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
  } cmd_pins_t;

  function automatic cmd_pins_t cmd_pins(cmd_e cmd);
    cmd_pins_t pins;
    case (cmd)
      CmdPre, CmdAct: pins = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b1};
      CmdRd, CmdWr:   pins = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b0};
      default:        pins = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1};
    endcase
    return pins;
  endfunction

  // A wait state lasts t-1 cycles; the timer counts load value down to 0 inclusive.
  function automatic logic [2:0] wait_load(int unsigned t);
    return (t >= 2) ? 3'(t - 2) : 3'd0;
  endfunction

endpackage

// File: rtl/dram_timer.sv
// Loadable 3-bit down-counter that saturates at zero; done flags a zero count.
module dram_timer (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  output logic       done_o
);

  logic [2:0] cnt_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q <= 3'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 3'd0) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign done_o = (cnt_q == 3'd0);

endmodule

// File: rtl/dram_ctrl.sv
// Single-bank open-page DRAM controller: one request at a time, exact command
// spacing, one-cycle completion pulse.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned T_RP  = DefTRp,
  parameter int unsigned T_RCD = DefTRcd,
  parameter int unsigned T_CL  = DefTCl,
  parameter int unsigned T_WR  = DefTWr
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        CSn,
  output logic        RASn,
  output logic        CASn,
  output logic [3:0]  WEn,
  output logic [10:0] A,
  output logic [31:0] D,
  input  logic [31:0] Q
);

  state_e      state_q, state_d;
  logic        open_valid_q;
  logic [10:0] open_row_q;
  logic [10:0] row_q;
  logic [9:0]  col_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        accept;
  logic        timer_load;
  logic [2:0]  timer_val;
  logic        timer_done;
  cmd_e        cmd;
  cmd_pins_t   pins;
  logic        unused_addr;

  assign unused_addr = ^{req_addr[31:23], req_addr[1:0]};

  dram_timer u_timer (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    timer_load = 1'b0;
    timer_val  = 3'd0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (open_valid_q && (req_addr[22:12] == open_row_q)) ? StCol : StPre;
        end
      end
      StPre: begin
        timer_load = 1'b1;
        timer_val  = wait_load(T_RP);
        state_d    = (T_RP == 1) ? StAct : StPreWait;
      end
      StPreWait: if (timer_done) state_d = StAct;
      StAct: begin
        timer_load = 1'b1;
        timer_val  = wait_load(T_RCD);
        state_d    = (T_RCD == 1) ? StCol : StActWait;
      end
      StActWait: if (timer_done) state_d = StCol;
      StCol: begin
        timer_load = 1'b1;
        if (write_q) begin
          timer_val = wait_load(T_WR);
          state_d   = (T_WR == 1) ? StDone : StColWait;
        end else begin
          timer_val = wait_load(T_CL);
          state_d   = (T_CL == 1) ? StDone : StColWait;
        end
      end
      StColWait: if (timer_done) state_d = StDone;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= StIdle;
      open_valid_q <= 1'b0;
      open_row_q   <= 11'd0;
      row_q        <= 11'd0;
      col_q        <= 10'd0;
      write_q      <= 1'b0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        row_q   <= req_addr[22:12];
        col_q   <= req_addr[11:2];
        write_q <= req_write;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (state_q == StAct) begin
        open_valid_q <= 1'b1;
        open_row_q   <= row_q;
      end
    end
  end

  // Outputs are gated by ARESET so the pins are quiet for the whole reset cycle.
  always_comb begin
    cmd        = CmdNop;
    WEn        = 4'hF;
    A          = 11'd0;
    D          = 32'd0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    if (!ARESET) begin
      case (state_q)
        StIdle: req_ready = 1'b1;
        StPre: begin
          cmd = CmdPre;
          WEn = 4'h0;
          A   = open_row_q;
        end
        StAct: begin
          cmd = CmdAct;
          A   = row_q;
        end
        StCol: begin
          A = {1'b0, col_q};
          if (write_q) begin
            cmd = CmdWr;
            WEn = ~wstrb_q;
            D   = wdata_q;
          end else begin
            cmd = CmdRd;
          end
        end
        StDone: begin
          resp_valid = 1'b1;
          resp_rdata = write_q ? 32'd0 : Q;
        end
        default: ;
      endcase
    end
  end

  assign pins = cmd_pins(cmd);
  assign CSn  = pins.cs_n;
  assign RASn = pins.ras_n;
  assign CASn = pins.cas_n;

endmodule

// File: tb/tb_dram_ctrl.sv
// Scoreboard bench for dram_ctrl: a transaction-level model predicts every pin
// event and its cycle; a negedge monitor compares what the DUT presents.
module tb_dram_ctrl;

  localparam int unsigned TRp  = 5;
  localparam int unsigned TRcd = 5;
  localparam int unsigned TCl  = 5;
  localparam int unsigned TWr  = 5;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        CSn, RASn, CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q;

  dram_ctrl #(
    .T_RP  (TRp),
    .T_RCD (TRcd),
    .T_CL  (TCl),
    .T_WR  (TWr)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .CSn        (CSn),
    .RASn       (RASn),
    .CASn       (CASn),
    .WEn        (WEn),
    .A          (A),
    .D          (D),
    .Q          (Q)
  );

  always #5 ACLK = ~ACLK;

  int unsigned cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic logic [31:0] qfun(int unsigned c);
    return (c * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction
  assign Q = qfun(cyc);

  typedef struct {
    int unsigned cyc;
    logic [2:0]  pins;   // {CSn,RASn,CASn}
    logic [3:0]  wen;
    logic [10:0] a;
    logic        chk_d;
    logic [31:0] d;
    logic        resp;
    logic [31:0] rdata;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Transaction-level model state
  bit          m_open_valid = 1'b0;
  logic [10:0] m_open_row = 11'd0;
  int unsigned m_idle = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge ACLK) begin
    ev_t e;
    check("req_ready", 64'(req_ready), 64'(!ARESET && (cyc >= m_idle)));
    if (!CSn || resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'({CSn, RASn, CASn, resp_valid}), 64'hE);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", 64'(cyc), 64'(e.cyc));
        check("cmd_pins", 64'({CSn, RASn, CASn}), 64'(e.pins));
        check("WEn", 64'(WEn), 64'(e.wen));
        check("resp_valid", 64'(resp_valid), 64'(e.resp));
        if (e.resp) check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        else        check("A", 64'(A), 64'(e.a));
        if (e.chk_d) check("D", 64'(D), 64'(e.d));
      end
    end else begin
      check("idle_pins", 64'({RASn, CASn, WEn}), 64'h3F);
      if (ARESET) check("reset_A_D_rdata", 64'({A, D, resp_rdata}), 64'd0);
    end
  end

  task automatic push_ev(input int unsigned c, input logic [2:0] pins, input logic [3:0] wen,
                         input logic [10:0] a, input logic chk_d, input logic [31:0] d,
                         input logic resp, input logic [31:0] rdata);
    ev_t e;
    e.cyc = c; e.pins = pins; e.wen = wen; e.a = a; e.chk_d = chk_d; e.d = d;
    e.resp = resp; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Called #1 after a posedge. Returns #1 after the accepting posedge.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit hold, output int unsigned acc);
    int unsigned issue, exp_acc, c;
    logic [10:0] row;
    bit got;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    got = 1'b0;
    issue = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge ACLK); #1;
      if (i == 0) issue = cyc;
      if (req_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      $display("FAIL accept_timeout: got no req_ready within 64 cycles, expected acceptance");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1);
    end
    acc = cyc;
    exp_acc = (issue > m_idle) ? issue : m_idle;
    check("accept_cycle", 64'(acc), 64'(exp_acc));
    row = addr[22:12];
    c = acc + 1;
    if (!(m_open_valid && row == m_open_row)) begin
      push_ev(c, 3'b001, 4'h0, m_open_row, 1'b0, 32'd0, 1'b0, 32'd0);
      c += TRp;
      push_ev(c, 3'b001, 4'hF, row, 1'b0, 32'd0, 1'b0, 32'd0);
      c += TRcd;
    end
    push_ev(c, 3'b010, wr ? ~wstrb : 4'hF, {1'b0, addr[11:2]}, wr, wdata, 1'b0, 32'd0);
    c += wr ? TWr : TCl;
    push_ev(c, 3'b111, 4'hF, 11'd0, 1'b0, 32'd0, 1'b1, wr ? 32'd0 : qfun(c));
    m_idle = c + 1;
    m_open_valid = 1'b1;
    m_open_row = row;
    @(posedge ACLK); #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
    end
  endtask

  // Called #1 after a posedge.
  task automatic do_reset(input int unsigned n);
    ARESET = 1'b1;
    exp_q.delete();
    m_open_valid = 1'b0;
    m_open_row = 11'd0;
    m_idle = 32'hFFFF_FFFF;
    repeat (n) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    m_idle = cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge ACLK);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int unsigned acc;
    logic [31:0] addr;
    @(posedge ACLK); #1;
    do_reset(3);
    // Directed: cold read, read hit, write hit, row miss
    do_req(1'b0, 32'h0000_1004, 32'd0, 4'h0, 1'b0, acc);
    drain();
    do_req(1'b0, 32'h0000_1008, 32'd0, 4'h0, 1'b0, acc);
    drain();
    do_req(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 4'b0101, 1'b0, acc);
    drain();
    do_req(1'b0, 32'h0000_2000, 32'd0, 4'h0, 1'b0, acc);
    drain();
    // Back-to-back with req_valid held through the busy period; wstrb=0 write included
    do_req(1'b1, 32'h0000_2010, 32'h1234_5678, 4'h0, 1'b1, acc);
    do_req(1'b0, 32'h0000_3010, 32'd0, 4'h0, 1'b1, acc);
    do_req(1'b0, 32'h0000_3014, 32'd0, 4'h0, 1'b0, acc);
    drain();
    // Reset in ACT_WAIT: no response, then a hit-looking address must go through PRE
    do_req(1'b0, 32'h0000_5000, 32'd0, 4'h0, 1'b0, acc);
    repeat (6) @(posedge ACLK);
    #1;
    do_reset(1);
    repeat (12) @(posedge ACLK);
    #1;
    do_req(1'b0, 32'h0000_5004, 32'd0, 4'h0, 1'b0, acc);
    drain();
    // Randomized traffic over a few rows so hits and misses mix
    for (int n = 0; n < 40; n++) begin
      addr = $urandom;
      addr[22:12] = 11'($urandom_range(0, 3)) + 11'h7F0;
      do_req(1'($urandom), addr, $urandom, 4'($urandom), bit'($urandom_range(0, 2) == 0), acc);
      if (!req_valid) repeat ($urandom_range(0, 2)) @(posedge ACLK);
    end
    req_valid = 1'b0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule
